// File: rtl/csel_pipe_adder_pkg.sv
// Shared constants, helpers and types for the pipelined carry-select adder.
package csa_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLOCK = 8;

   // Number of carry-select slices an operand of the given width splits into.
   function automatic int nblk(input int width, input int block);
      return width / block;
   endfunction

   // Result held in the output stage at the default operand width.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] s;
      logic                 c_out;
      logic                 ovf;
   } csa_result_t;

endpackage

// File: rtl/sdb_inner.sv
// One slice of the carry-select adder.
// It is a ripple adder for a fixed carry-in.
// The slice uses generate (a & b) and the registered propagate (a ^ b).
module sdb_inner #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] i_a,
   input  logic [BLOCK-1:0] i_b,
   input  logic [BLOCK-1:0] i_p,
   input  logic             i_cin,
   output logic [BLOCK-1:0] o_s,
   output logic             o_c
);

   logic [BLOCK:0]   w_carry;
   logic [BLOCK-1:0] w_gen;

   // Ripple the slice carry from the fixed carry-in, then form the sum bits from propagate.
   always_comb begin
      w_gen      = i_a & i_b;
      w_carry    = '0;
      w_carry[0] = i_cin;
      for (int i = 0; i < BLOCK; i++) begin
         w_carry[i+1] = w_gen[i] | (i_p[i] & w_carry[i]);
      end
      o_s = i_p ^ w_carry[BLOCK-1:0];
      o_c = w_carry[BLOCK];
   end

endmodule

// File: rtl/csel_pipe_adder.sv
// Two-stage pipelined carry-select adder with a valid/ready handshake on both sides.
// Stage 1 registers the operands and the propagate bits.
// Between the stages, each slice is summed for both carry-in values.
// The slice carries then select the correct half down the chain.
// Stage 2 registers the sum, the carry-out and the signed overflow.
module csel_pipe_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NBLK = nblk(WIDTH, BLOCK);

   // A slice width that does not tile the operand cannot be built.
   if (BLOCK < 1) begin : g_badBlock
      $fatal(1, "csel_pipe_adder: BLOCK must be at least 1");
   end else if (WIDTH % BLOCK != 0) begin : g_badWidth
      $fatal(1, "csel_pipe_adder: WIDTH must be a multiple of BLOCK");
   end

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             c_out;
      logic             ovf;
   } result_t;

   logic             r_s1Valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_p;
   logic             r_cin;

   logic             r_outValid;
   result_t          r_res;

   logic             w_adv1;
   logic             w_adv2;

   logic [NBLK-1:0][BLOCK-1:0] w_s0;
   logic [NBLK-1:0][BLOCK-1:0] w_s1;
   logic [NBLK-1:0]            w_c0;
   logic [NBLK-1:0]            w_c1;
   logic [NBLK:0]              w_sel;
   logic [WIDTH-1:0]           w_sum;
   logic                       w_ovf;

   // Output stage moves when it is empty or being drained.
   // Input stage moves when it is empty or can hand over.
   assign w_adv2    = !r_outValid || out_ready;
   assign w_adv1    = !r_s1Valid || w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_outValid;
   assign s         = r_res.s;
   assign c_out     = r_res.c_out;
   assign ovf       = r_res.ovf;

   // Stage 1 captures operands and propagate bits whenever it is allowed to advance and data is offered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_p       <= '0;
         r_cin     <= 1'b0;
      end else if (w_adv1) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_p   <= a ^ b;
            r_cin <= c_in;
         end
      end
   end

   // Each slice gets a carry-in-0 adder and a carry-in-1 adder, so only the select chain remains serial.
   for (genvar k = 0; k < NBLK; k++) begin : g_slice
      sdb_inner #(.BLOCK(BLOCK)) u_cin0 (
         .i_a   (r_a[k*BLOCK +: BLOCK]),
         .i_b   (r_b[k*BLOCK +: BLOCK]),
         .i_p   (r_p[k*BLOCK +: BLOCK]),
         .i_cin (1'b0),
         .o_s   (w_s0[k]),
         .o_c   (w_c0[k])
      );
      sdb_inner #(.BLOCK(BLOCK)) u_cin1 (
         .i_a   (r_a[k*BLOCK +: BLOCK]),
         .i_b   (r_b[k*BLOCK +: BLOCK]),
         .i_p   (r_p[k*BLOCK +: BLOCK]),
         .i_cin (1'b1),
         .o_s   (w_s1[k]),
         .o_c   (w_c1[k])
      );
   end

   // Walk the block-select chain from the stage-1 carry-in, picking each slice's sum and its outgoing carry.
   // Overflow compares the operand sign bits with the selected sum sign bit.
   always_comb begin
      w_sel    = '0;
      w_sum    = '0;
      w_sel[0] = r_cin;
      for (int k = 0; k < NBLK; k++) begin
         w_sum[k*BLOCK +: BLOCK] = w_sel[k] ? w_s1[k] : w_s0[k];
         w_sel[k+1]              = w_sel[k] ? w_c1[k] : w_c0[k];
      end
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
   end

   // Stage 2 takes the resolved result when it may advance and stage 1 holds a valid operation.
   // Otherwise the stage holds its outputs stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_res      <= '0;
      end else if (w_adv2) begin
         r_outValid <= r_s1Valid;
         if (r_s1Valid) begin
            r_res.s     <= w_sum;
            r_res.c_out <= w_sel[NBLK];
            r_res.ovf   <= w_ovf;
         end
      end
   end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Self-checking bench for csel_pipe_adder.
// A scoreboard queue receives the expected result for every accepted operation.
// Each result is checked when the adder delivers it.
// Directed steps cover reset, carry boundaries, overflow, backpressure, reset in flight, and a random soak.
module tb_csel_pipe_adder;
   import csa_pkg::*;

   localparam int W = DEF_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         c_out;
   logic         ovf;

   int           checks = 0;
   int           errors = 0;
   csa_result_t  sbQueue[$];
   logic         fire;
   int           acc;

   csel_pipe_adder #(.WIDTH(W), .BLOCK(DEF_BLOCK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   // Free-running clock with a period of 10 time units.
   always #5 clk = ~clk;

   // Reference result from a plain wide addition.
   function automatic csa_result_t modelAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0]  full;
      csa_result_t r;
      full    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s     = full[W-1:0];
      r.c_out = full[W];
      r.ovf   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop and compare on every output transfer, push the model result on every input transfer.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            csa_result_t e;
            checkOutput("sb_pending", W'(sbQueue.size() != 0), W'(1));
            if (sbQueue.size() != 0) begin
               e = sbQueue.pop_front();
               checkOutput("sb_sum", s, e.s);
               checkOutput("sb_c_out", W'(c_out), W'(e.c_out));
               checkOutput("sb_ovf", W'(ovf), W'(e.ovf));
            end
         end
         if (in_valid && in_ready) sbQueue.push_back(modelAdd(a, b, c_in));
      end
   end

   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      a        = x;
      b        = y;
      c_in     = ci;
      in_valid = 1'b1;
      checkOutput("accept_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic runDirected(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                              input logic [W-1:0] es, input logic ec, input logic eo);
      out_ready = 1'b1;
      applyStimulus(x, y, ci);
      checkOutput({tag, "_lat_s1"}, W'(out_valid), W'(0));
      @(posedge clk); #1;
      checkOutput({tag, "_lat_s2"}, W'(out_valid), W'(1));
      checkOutput({tag, "_s"}, s, es);
      checkOutput({tag, "_c_out"}, W'(c_out), W'(ec));
      checkOutput({tag, "_ovf"}, W'(ovf), W'(eo));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] bpA [3];
      logic [W-1:0] bpB [3];
      logic [W-1:0] bpSum [3];
      int           waitCyc;
      bpA   = '{32'd1, 32'd3, 32'd5};
      bpB   = '{32'd2, 32'd4, 32'd6};
      bpSum = '{32'd3, 32'd7, 32'd11};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      out_ready = 1'b1;

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", W'(out_valid), W'(0));
      checkOutput("rst_s", s, W'(0));
      checkOutput("rst_c_out", W'(c_out), W'(0));
      checkOutput("rst_ovf", W'(ovf), W'(0));
      rst = 1'b0;
      #1;
      checkOutput("rst_in_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;

      // Carry boundaries and signed overflow.
      runDirected("blk_cross", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      runDirected("full_prop", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      runDirected("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      runDirected("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

      // Backpressure: three ops offered back-to-back while the consumer stalls for four cycles.
      out_ready = 1'b0;
      acc       = 0;
      a         = bpA[0];
      b         = bpB[0];
      c_in      = 1'b0;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) begin
            acc++;
            if (acc < 3) begin
               a = bpA[acc];
               b = bpB[acc];
            end
         end
         if (cyc == 1) checkOutput("bp_in_ready_low", W'(in_ready), W'(0));
         if (cyc >= 1) begin
            checkOutput("bp_hold_valid", W'(out_valid), W'(1));
            checkOutput("bp_hold_s", s, W'(3));
         end
      end
      checkOutput("bp_accept_count", W'(acc), W'(2));
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("bp_no_gap", W'(out_valid), W'(1));
         checkOutput("bp_order", s, bpSum[k]);
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) begin
            acc++;
            if (acc >= 3) in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput("bp_drained", W'(out_valid), W'(0));
      checkOutput("bp_sb_empty", W'(sbQueue.size()), W'(0));

      // Reset with both stages occupied.
      @(posedge clk); #1;
      out_ready = 1'b0;
      a         = 32'd10;
      b         = 32'd20;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      a = 32'd30;
      b = 32'd40;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("full_in_ready", W'(in_ready), W'(0));
      checkOutput("full_out_valid", W'(out_valid), W'(1));
      #1;
      rst = 1'b1;
      sbQueue.delete();
      #1;
      checkOutput("rst_mid_valid", W'(out_valid), W'(0));
      checkOutput("rst_mid_s", s, W'(0));
      @(posedge clk); #2;
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("post_rst_idle", W'(out_valid), W'(0));
      end

      // Random soak with random handshakes on both sides.
      @(posedge clk); #1;
      for (int n = 0; n < 10000; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         a         = $urandom();
         b         = $urandom();
         c_in      = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitCyc   = 0;
      while (sbQueue.size() != 0 && waitCyc < 20) begin
         @(posedge clk); #1;
         waitCyc++;
      end
      checkOutput("soak_drain", W'(sbQueue.size()), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
